// File: rtl/fir_sm_fifo.sv
// fir_sm_fifo: first-word fall-through register FIFO on the FIR sm_* stream,
// carrying tlast and reporting fill level and per-frame pop statistics.
module fir_sm_fifo #(
    parameter int pDATA_WIDTH = 32,
    parameter int pDEPTH      = 16,
    parameter int pAFULL      = 12
) (
    input  logic                     axis_clk,
    input  logic                     axis_rst,
    input  logic                     s_tvalid,
    output logic                     s_tready,
    input  logic [pDATA_WIDTH-1:0]   s_tdata,
    input  logic                     s_tlast,
    output logic                     m_tvalid,
    input  logic                     m_tready,
    output logic [pDATA_WIDTH-1:0]   m_tdata,
    output logic                     m_tlast,
    output logic [$clog2(pDEPTH):0]  level,
    output logic                     afull,
    output logic [31:0]              frame_samples,
    output logic [15:0]              frame_count,
    output logic                     frame_done
);
    localparam int AW = $clog2(pDEPTH);
    localparam int LW = AW + 1;
    localparam logic [LW-1:0] FULL = LW'(pDEPTH);
    localparam logic [LW-1:0] AF   = LW'(pAFULL);
    localparam logic [LW-1:0] LONE = LW'(1);
    localparam logic [AW-1:0] PONE = AW'(1);

    logic [pDATA_WIDTH:0] mem [pDEPTH];
    logic [AW-1:0]        wr_ptr, rd_ptr;
    logic [LW-1:0]        level_n;
    logic                 push, pop;

    assign s_tready = !axis_rst && level != FULL;
    assign m_tvalid = level != '0;
    assign {m_tlast, m_tdata} = m_tvalid ? mem[rd_ptr] : '0;
    assign push = s_tvalid && s_tready;
    assign pop  = m_tvalid && m_tready;

    always_comb begin
        level_n = push && !pop ? level + LONE : pop && !push ? level - LONE : level;
    end

    // Storage is deliberately left out of reset; only bookkeeping is cleared.
    always_ff @(posedge axis_clk) begin
        if (push)
            mem[wr_ptr] <= {s_tlast, s_tdata};
    end

    always_ff @(posedge axis_clk) begin
        if (axis_rst) begin
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            level         <= '0;
            afull         <= 1'b0;
            frame_samples <= '0;
            frame_count   <= '0;
            frame_done    <= 1'b0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + PONE;
            if (pop)
                rd_ptr <= rd_ptr + PONE;
            level      <= level_n;
            afull      <= level_n >= AF;
            frame_done <= pop && m_tlast;
            if (pop) begin
                frame_samples <= m_tlast ? '0 : frame_samples + 32'd1;
                frame_count   <= m_tlast ? frame_count + 16'd1 : frame_count;
            end
        end
    end
endmodule

// File: tb/tb_fir_sm_fifo.sv
// tb_fir_sm_fifo: queue-based reference model of fir_sm_fifo checked every cycle,
// with directed scenarios, literal pins and a randomized soak.
module tb_fir_sm_fifo;
    localparam int DEPTH = 16;
    localparam int AFULL = 12;

    logic        axis_clk, axis_rst;
    logic        s_tvalid, s_tready, s_tlast;
    logic [31:0] s_tdata;
    logic        m_tvalid, m_tready, m_tlast;
    logic [31:0] m_tdata;
    logic [4:0]  level;
    logic        afull;
    logic [31:0] frame_samples;
    logic [15:0] frame_count;
    logic        frame_done;

    fir_sm_fifo #(.pDATA_WIDTH(32), .pDEPTH(DEPTH), .pAFULL(AFULL)) dut (
        .axis_clk(axis_clk), .axis_rst(axis_rst),
        .s_tvalid(s_tvalid), .s_tready(s_tready), .s_tdata(s_tdata), .s_tlast(s_tlast),
        .m_tvalid(m_tvalid), .m_tready(m_tready), .m_tdata(m_tdata), .m_tlast(m_tlast),
        .level(level), .afull(afull), .frame_samples(frame_samples),
        .frame_count(frame_count), .frame_done(frame_done)
    );

    initial axis_clk = 1'b0;
    always #5 axis_clk = ~axis_clk;

    int npass = 0;
    int total = 0;

    // Reference model: a queue of {tlast, data} plus frame counters.
    logic [32:0] q[$];
    logic [31:0] m_fs;
    logic [15:0] m_fc;
    bit          m_fd;
    bit          armed = 0;
    bit          last_push;

    task automatic chk(input string n, input logic [63:0] a, input logic [63:0] e);
        total++;
        if (a !== e)
            $display("FAIL %s: got %0h expected %0h at %0t", n, a, e, $time);
        else
            npass++;
    endtask

    task automatic model_step();
        bit push, pop;
        logic [32:0] b;
        push = s_tvalid && !axis_rst && q.size() < DEPTH;
        pop  = m_tready && q.size() > 0;
        last_push = 0;
        if (axis_rst) begin
            q.delete();
            m_fs = 0;
            m_fc = 0;
            m_fd = 0;
            armed = 1;
        end else begin
            m_fd = 0;
            if (pop) begin
                b = q.pop_front();
                if (b[32]) begin
                    m_fs = 0;
                    m_fc = m_fc + 16'd1;
                    m_fd = 1;
                end else
                    m_fs = m_fs + 32'd1;
            end
            if (push) begin
                q.push_back({s_tlast, s_tdata});
                last_push = 1;
            end
        end
    endtask

    task automatic cyc();
        @(posedge axis_clk);
        model_step();
        #1;
    endtask

    task automatic step(input bit v, input logic [31:0] d, input bit l, input bit r);
        s_tvalid = v;
        s_tdata  = d;
        s_tlast  = l;
        m_tready = r;
        cyc();
    endtask

    always @(negedge axis_clk) begin
        if (armed) begin
            chk("s_tready", s_tready, !axis_rst && q.size() < DEPTH);
            chk("m_tvalid", m_tvalid, q.size() > 0);
            chk("m_tdata", m_tdata, q.size() > 0 ? q[0][31:0] : 32'd0);
            chk("m_tlast", m_tlast, q.size() > 0 ? q[0][32] : 1'b0);
            chk("level", level, q.size());
            chk("afull", afull, q.size() >= AFULL);
            chk("frame_samples", frame_samples, m_fs);
            chk("frame_count", frame_count, m_fc);
            chk("frame_done", frame_done, m_fd);
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int v, n, fdc, acc17;
        bit have, rl;
        logic [31:0] rd;
        axis_rst = 1;
        s_tvalid = 0; s_tdata = 0; s_tlast = 0; m_tready = 0;
        step(0, 0, 0, 0);
        step(0, 0, 0, 0);
        chk("rst_s_tready", s_tready, 0);
        chk("rst_level", level, 0);
        chk("rst_m_tvalid", m_tvalid, 0);
        axis_rst = 0;
        #1;
        chk("release_s_tready", s_tready, 1);

        // single beat
        step(1, 32'h5, 0, 1);
        s_tvalid = 0;
        chk("single_tvalid", m_tvalid, 1);
        chk("single_tdata", m_tdata, 32'h5);
        chk("single_level1", level, 1);
        step(0, 0, 0, 1);
        chk("single_level0", level, 0);
        chk("single_fs", frame_samples, 1);

        // fill to full, then drain
        v = 1;
        for (int i = 0; i < 20; i++) begin
            step(v <= 17, v, 0, 0);
            if (last_push) v++;
        end
        chk("fill_level", level, 16);
        chk("fill_s_tready", s_tready, 0);
        chk("fill_afull", afull, 1);
        acc17 = -1;
        for (int i = 0; i < 40; i++) begin
            s_tvalid = v <= 17;
            #1;
            if (v == 17 && s_tready && acc17 < 0) acc17 = i;
            step(v <= 17, v, 0, 1);
            if (last_push) v++;
        end
        chk("fill_acc17_cycle", acc17, 1);
        chk("fill_drained", level, 0);
        chk("fill_fs", frame_samples, 18);

        // 600-beat frame, consumer ready 1-on/2-off
        n = 0; fdc = 0; rd = $urandom;
        for (int c = 0; c < 3000 && !(n == 600 && q.size() == 0); c++) begin
            step(n < 600, rd, n == 599, c % 3 == 0);
            if (last_push) begin n++; rd = $urandom; end
            if (frame_done) fdc++;
        end
        chk("frame600_pushed", n, 600);
        chk("frame600_empty", level, 0);
        chk("frame600_done_pulses", fdc, 1);
        chk("frame600_count", frame_count, 1);
        chk("frame600_fs", frame_samples, 0);

        // simultaneous push/pop at level 5
        for (int i = 0; i < 5; i++) step(1, 100 + i, 0, 0);
        for (int i = 0; i < 20; i++) step(1, 200 + i, 0, 1);
        chk("simul_level", level, 5);
        for (int i = 0; i < 10; i++) step(0, 0, 0, 1);

        // reset mid-stream at level 7, frame_samples 4
        axis_rst = 1;
        step(0, 0, 0, 0);
        axis_rst = 0;
        for (int i = 0; i < 11; i++) step(1, 300 + i, 0, 0);
        for (int i = 0; i < 4; i++) step(0, 0, 0, 1);
        chk("pre_rst_level", level, 7);
        chk("pre_rst_fs", frame_samples, 4);
        axis_rst = 1;
        step(1, 999, 1, 1);
        chk("midrst_level", level, 0);
        chk("midrst_m_tvalid", m_tvalid, 0);
        chk("midrst_fs", frame_samples, 0);
        chk("midrst_fc", frame_count, 0);
        chk("midrst_fd", frame_done, 0);
        chk("midrst_s_tready", s_tready, 0);
        axis_rst = 0;

        // back-to-back frames of 3 and 2 beats
        fdc = 0;
        for (int i = 0; i < 9; i++) begin
            step(i < 5, i + 1, i == 2 || i == 4, 1);
            if (frame_done) fdc++;
        end
        chk("b2b_done_pulses", fdc, 2);
        chk("b2b_count", frame_count, 2);

        // randomized soak with shifting ready biases
        have = 0; rd = 0; rl = 0;
        for (int c = 0; c < 2500; c++) begin
            axis_rst = $urandom_range(0, 499) == 0;
            if (!have) begin
                have = $urandom_range(0, 3) >= (c / 250) % 4;
                rd = $urandom;
                rl = $urandom_range(0, 7) == 0;
            end
            step(have, rd, rl, $urandom_range(0, 3) <= (c / 300) % 4);
            if (last_push) have = 0;
        end
        axis_rst = 0;
        for (int i = 0; i < 40; i++) step(0, 0, 0, 1);
        chk("soak_drained", level, 0);

        $display("%0d/%0d checks passed", npass, total);
        $finish;
    end
endmodule
